// File: rtl/calc_pkg.sv
// calc_pkg: shared constants, state encoding and helpers
// for the calc_n decimal calculator core.
package calc_pkg;

   localparam logic [3:0] CMD_ADD = 4'b1010;
   localparam logic [3:0] CMD_SUB = 4'b1011;
   localparam logic [3:0] CMD_MUL = 4'b1100;
   localparam logic [3:0] CMD_DIV = 4'b1101;
   localparam logic [3:0] CMD_EQ  = 4'b1110;
   localparam logic [3:0] CMD_BS  = 4'b1111;

   localparam logic [1:0] STAT_ERR   = 2'b00;
   localparam logic [1:0] STAT_BUSY  = 2'b01;
   localparam logic [1:0] STAT_READY = 2'b10;

   typedef enum logic [2:0] {
      S_ENTRY_A = 3'b000,
      S_ENTRY_B = 3'b001,
      S_EXEC    = 3'b010,
      S_SHOW    = 3'b011,
      S_ERR     = 3'b100,
      S_HOLD    = 3'b101
   } calc_state_t;

   // Largest displayable value, 10^digits - 1.
   function automatic longint unsigned calc_max(input int digits);
      longint unsigned v;
      v = 1;
      for (int i = 0; i < digits; i++) v = v * 10;
      return v - 1;
   endfunction

endpackage

// File: rtl/calc_bin2bcd.sv
// calc_bin2bcd: sequential double-dabble converter.
// First shift happens on the start edge; done after W cycles.
module calc_bin2bcd
   import calc_pkg::*;
#(
   parameter int W      = 27,
   parameter int DIGITS = 8
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic [W-1:0]          bin,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd
);

   localparam int CW = $clog2(W + 1);

   logic [4*DIGITS-1:0]   bcd_q;
   logic [W-1:0]          sh_q;
   logic [CW-1:0]         cnt_q;
   logic                  busy_q;
   logic [4*DIGITS-1:0]   src_bcd;
   logic [W-1:0]          src_sh;
   logic [4*DIGITS-1:0]   adj;
   logic [4*DIGITS+W-1:0] cat;
   logic [4*DIGITS+W-1:0] cat_sh;

   // One iteration: add-3 on every digit >= 5, then shift left.
   always_comb begin
      src_bcd = start ? '0 : bcd_q;
      src_sh  = start ? bin : sh_q;
      adj     = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (src_bcd[4*i +: 4] >= 4'd5)
            adj[4*i +: 4] = src_bcd[4*i +: 4] + 4'd3;
         else
            adj[4*i +: 4] = src_bcd[4*i +: 4];
      end
      cat    = {adj, src_sh};
      cat_sh = cat << 1;
   end

   // Iteration registers; result held until the next start.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         bcd_q  <= '0;
         sh_q   <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
      end else if (start) begin
         bcd_q  <= cat_sh[4*DIGITS+W-1:W];
         sh_q   <= cat_sh[W-1:0];
         cnt_q  <= CW'(W - 1);
         busy_q <= 1'b1;
      end else if (busy_q && cnt_q != '0) begin
         bcd_q  <= cat_sh[4*DIGITS+W-1:W];
         sh_q   <= cat_sh[W-1:0];
         cnt_q  <= cnt_q - CW'(1);
      end
   end

   assign done = busy_q && (cnt_q == '0);
   assign bcd  = bcd_q;

endmodule

// File: rtl/calc_n.sv
// calc_n: decimal calculator core with multi-cycle mul/div
// and a BCD digit scan after every accepted command.
module calc_n
   import calc_pkg::*;
#(
   parameter int DIGITS = 8,
   parameter int W      = 27
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [3:0]                cmd,
   input  logic                      cmd_valid,
   output logic [1:0]                status,
   output logic [3:0]                data,
   output logic [$clog2(DIGITS)-1:0] pos,
   output logic                      disp_we,
   output logic [2:0]                state
);

   localparam int PW = $clog2(DIGITS);
   localparam int CW = $clog2(W + DIGITS + 1);
   localparam int IW = $clog2(W + 1);
   localparam logic [W-1:0]  MAX       = W'(calc_max(DIGITS));
   localparam logic [CW-1:0] SHOW_LAST = CW'(W + DIGITS - 1);
   localparam logic [IW-1:0] ITER_LAST = IW'(W - 1);

   calc_state_t st_q, st_d, tgt_q, tgt_d;
   logic [W-1:0]   acc_q, acc_d, rega_q, rega_d, regb_q, regb_d;
   logic [3:0]     op_q, op_d;
   logic [2*W-1:0] wk_q, wk_d;
   logic [IW-1:0]  it_q, it_d;
   logic [CW-1:0]  sc_q, sc_d;

   logic [W-1:0]   entry_acc;
   logic [W+3:0]   acc10;
   logic           digit_ok;
   logic [W:0]     add_sum;
   logic [W:0]     msum;
   logic [2*W-1:0] mul_nx;
   logic [W:0]     cand;
   logic [W+1:0]   dsub;
   logic [2*W-1:0] div_nx;
   logic [W-1:0]   ex_res;
   logic           ex_bad;
   logic           ex_iter;
   logic           ex_last;

   logic                conv_start;
   logic                conv_done;
   logic [4*DIGITS-1:0] conv_bcd;
   logic                scanning;
   logic [PW-1:0]       scan_pos;

   // Digit entry works on a cleared accumulator when a result is held.
   assign entry_acc = (st_q == S_HOLD) ? '0 : acc_q;
   assign acc10 = ({4'b0, entry_acc} << 3) + ({4'b0, entry_acc} << 1)
                + {{W{1'b0}}, cmd};
   assign digit_ok = acc10 <= {4'b0, MAX};

   // Shift-add multiply step and restoring divide step on wk.
   assign add_sum = {1'b0, rega_q} + {1'b0, regb_q};
   assign msum    = {1'b0, wk_q[2*W-1:W]} + {1'b0, rega_q};
   assign mul_nx  = wk_q[0] ? {msum, wk_q[W-1:1]}
                            : {1'b0, wk_q[2*W-1:1]};
   assign cand    = wk_q[2*W-1:W-1];
   assign dsub    = {1'b0, cand} - {2'b0, regb_q};
   assign div_nx  = (dsub[W+1:W] != 2'b00)
                  ? {cand[W-1:0], wk_q[W-2:0], 1'b0}
                  : {dsub[W-1:0], wk_q[W-2:0], 1'b1};

   // Result and error selection for the operation in EXEC.
   always_comb begin
      ex_res  = '0;
      ex_bad  = 1'b0;
      ex_iter = 1'b0;
      unique case (op_q)
         CMD_SUB: begin
            ex_bad = regb_q > rega_q;
            ex_res = rega_q - regb_q;
         end
         CMD_MUL: begin
            ex_iter = 1'b1;
            ex_bad  = mul_nx > {{W{1'b0}}, MAX};
            ex_res  = mul_nx[W-1:0];
         end
         CMD_DIV: begin
            ex_iter = 1'b1;
            ex_bad  = regb_q == '0;
            ex_res  = div_nx[W-1:0];
         end
         default: begin
            ex_bad = add_sum > {1'b0, MAX};
            ex_res = add_sum[W-1:0];
         end
      endcase
      ex_last = !ex_iter || (it_q == ITER_LAST);
   end

   // Next-state and datapath update logic.
   always_comb begin
      st_d   = st_q;
      tgt_d  = tgt_q;
      acc_d  = acc_q;
      rega_d = rega_q;
      regb_d = regb_q;
      op_d   = op_q;
      wk_d   = wk_q;
      it_d   = it_q;
      sc_d   = sc_q;
      unique case (st_q)
         S_ENTRY_A, S_ENTRY_B, S_HOLD: begin
            if (cmd_valid) begin
               unique case (1'b1)
                  (cmd <= 4'd9): begin
                     acc_d = digit_ok ? acc10[W-1:0] : entry_acc;
                     tgt_d = (st_q == S_ENTRY_B) ? S_ENTRY_B : S_ENTRY_A;
                     st_d  = S_SHOW;
                  end
                  (cmd == CMD_BS): begin
                     acc_d = acc_q / W'(10);
                     tgt_d = (st_q == S_ENTRY_B) ? S_ENTRY_B : S_ENTRY_A;
                     st_d  = S_SHOW;
                  end
                  (cmd == CMD_EQ): begin
                     if (st_q == S_ENTRY_B) begin
                        regb_d = acc_q;
                        it_d   = '0;
                        wk_d   = (op_q == CMD_DIV) ? {{W{1'b0}}, rega_q}
                                                   : {{W{1'b0}}, acc_q};
                        st_d   = S_EXEC;
                     end
                  end
                  default: begin
                     if (st_q == S_ENTRY_B) begin
                        st_d = S_ERR;
                     end else begin
                        rega_d = acc_q;
                        op_d   = cmd;
                        acc_d  = '0;
                        tgt_d  = S_ENTRY_B;
                        st_d   = S_SHOW;
                     end
                  end
               endcase
            end
         end
         S_EXEC: begin
            wk_d = (op_q == CMD_DIV) ? div_nx : mul_nx;
            it_d = it_q + IW'(1);
            if (ex_last) begin
               it_d = '0;
               if (ex_bad) begin
                  st_d = S_ERR;
               end else begin
                  acc_d = ex_res;
                  tgt_d = S_HOLD;
                  st_d  = S_SHOW;
               end
            end
         end
         S_SHOW: begin
            sc_d = sc_q + CW'(1);
            if (sc_q == SHOW_LAST) begin
               sc_d = '0;
               st_d = tgt_q;
            end
         end
         S_ERR: begin
            st_d = S_ERR;
         end
         default: begin
            st_d = S_ENTRY_A;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         st_q   <= S_ENTRY_A;
         tgt_q  <= S_ENTRY_A;
         acc_q  <= '0;
         rega_q <= '0;
         regb_q <= '0;
         op_q   <= '0;
         wk_q   <= '0;
         it_q   <= '0;
         sc_q   <= '0;
      end else begin
         st_q   <= st_d;
         tgt_q  <= tgt_d;
         acc_q  <= acc_d;
         rega_q <= rega_d;
         regb_q <= regb_d;
         op_q   <= op_d;
         wk_q   <= wk_d;
         it_q   <= it_d;
         sc_q   <= sc_d;
      end
   end

   assign conv_start = (st_q == S_SHOW) && (sc_q == '0);

   calc_bin2bcd #(
      .W      (W),
      .DIGITS (DIGITS)
   ) u_bcd (
      .clock (clock),
      .reset (reset),
      .start (conv_start),
      .bin   (acc_q),
      .done  (conv_done),
      .bcd   (conv_bcd)
   );

   // Scan runs once conversion is done, one digit per cycle.
   always_comb begin
      scanning = (st_q == S_SHOW) && conv_done && (sc_q != '0);
      scan_pos = PW'(sc_q - CW'(W));
      disp_we  = scanning;
      pos      = scanning ? scan_pos : '0;
      data     = scanning ? conv_bcd[{scan_pos, 2'b00} +: 4] : 4'd0;
   end

   // Handshake status derived from the current state.
   always_comb begin
      status = STAT_READY;
      unique case (st_q)
         S_ERR:          status = STAT_ERR;
         S_EXEC, S_SHOW: status = STAT_BUSY;
         default:        status = STAT_READY;
      endcase
   end

   assign state = st_q;

endmodule

// File: tb/tb_calc_n.sv
// tb_calc_n: directed and random command sequences checked
// against an arithmetic model of the calculator.
module tb_calc_n;

   localparam int DIGITS = 8;
   localparam int W      = 27;
   localparam longint MAXV = 64'd99999999;
   localparam int BUDGET = 2*W + DIGITS + 40;

   localparam int MA = 0;
   localparam int MB = 1;
   localparam int ME = 4;
   localparam int MH = 5;

   localparam int K_SHOW = 0;
   localparam int K_ERR  = 1;
   localparam int K_IGN  = 2;
   localparam int K_DROP = 3;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] cmd = 4'd0;
   logic       cmd_valid = 1'b0;
   logic [1:0] status;
   logic [3:0] data;
   logic [2:0] pos;
   logic       disp_we;
   logic [2:0] state;

   int total = 0;
   int bad   = 0;

   longint     m_acc, m_a, m_b;
   logic [3:0] m_op;
   int         m_st;
   longint     g_shown;

   calc_n #(.DIGITS(DIGITS), .W(W)) dut (
      .clock     (clock),
      .reset     (reset),
      .cmd       (cmd),
      .cmd_valid (cmd_valid),
      .status    (status),
      .data      (data),
      .pos       (pos),
      .disp_we   (disp_we),
      .state     (state)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_acc = 0; m_a = 0; m_b = 0; m_op = 4'd0; m_st = MA;
   endtask

   task automatic predict(input logic [3:0] c, output int kind,
                          output int lat);
      longint base, r;
      bit e;
      kind = K_SHOW; lat = 0; r = 0; e = 0;
      if (m_st == ME) begin
         kind = K_DROP;
      end else if (c <= 4'd9) begin
         base = (m_st == MH) ? 0 : m_acc;
         if (base * 10 + longint'(c) <= MAXV)
            m_acc = base * 10 + longint'(c);
         else
            m_acc = base;
         m_st = (m_st == MB) ? MB : MA;
      end else if (c == 4'd15) begin
         m_acc = m_acc / 10;
         m_st = (m_st == MB) ? MB : MA;
      end else if (c == 4'd14) begin
         if (m_st != MB) begin
            kind = K_IGN;
         end else begin
            m_b = m_acc;
            lat = (m_op == 4'd10 || m_op == 4'd11) ? 1 : W;
            case (m_op)
               4'd11: begin r = m_a - m_b; e = m_b > m_a; end
               4'd12: begin r = m_a * m_b; e = r > MAXV; end
               4'd13: begin e = (m_b == 0); r = e ? 0 : m_a / m_b; end
               default: begin r = m_a + m_b; e = r > MAXV; end
            endcase
            if (e) begin
               kind = K_ERR; m_st = ME;
            end else begin
               m_acc = r; m_st = MH;
            end
         end
      end else begin
         if (m_st == MB) begin
            kind = K_ERR; m_st = ME;
         end else begin
            m_a = m_acc; m_op = c; m_acc = 0; m_st = MB;
         end
      end
   endtask

   task automatic run_cmd(input logic [3:0] c, input int glitch);
      int kind, lat, first, nwe, endi;
      longint shown, p10;
      logic [1:0] st1;
      predict(c, kind, lat);
      first = 0; nwe = 0; endi = 0; shown = 0; p10 = 1; st1 = 2'bxx;
      @(negedge clock);
      cmd = c; cmd_valid = 1'b1;
      @(posedge clock);
      for (int i = 1; i <= BUDGET; i++) begin
         @(negedge clock);
         if (i == 1) cmd_valid = 1'b0;
         if (glitch > 0 && i == glitch) begin
            cmd = 4'd7; cmd_valid = 1'b1;
         end
         if (glitch > 0 && i == glitch + 1) cmd_valid = 1'b0;
         if (i == 1) st1 = status;
         if (disp_we) begin
            if (first == 0) first = i;
            chk("scan_pos", 64'(pos), 64'(nwe));
            shown = shown + longint'(data) * p10;
            p10 = p10 * 10;
            nwe++;
         end
         if (status != 2'b01) begin
            endi = i;
            break;
         end
      end
      cmd_valid = 1'b0;
      g_shown = shown;
      chk("finished_in_budget", 64'(endi != 0), 64'(1));
      case (kind)
         K_SHOW: begin
            chk("busy_after_accept", 64'(st1), 64'(2'b01));
            chk("first_we_cycle", 64'(first), 64'(lat + W + 1));
            chk("we_count", 64'(nwe), 64'(DIGITS));
            chk("ready_cycle", 64'(endi), 64'(lat + W + DIGITS + 1));
            chk("status_ready", 64'(status), 64'(2'b10));
            chk("state_after", 64'(state), 64'(m_st));
            chk("shown_value", 64'(shown), 64'(m_acc));
         end
         K_ERR: begin
            if (lat > 0) chk("busy_before_err", 64'(st1), 64'(2'b01));
            chk("err_cycle", 64'(endi), 64'(lat + 1));
            chk("status_err", 64'(status), 64'(2'b00));
            chk("err_no_we", 64'(nwe), 64'(0));
            chk("state_err", 64'(state), 64'(ME));
         end
         default: begin
            chk("no_busy", 64'(endi), 64'(1));
            chk("status_kept", 64'(status),
                64'((kind == K_IGN) ? 2'b10 : 2'b00));
            chk("no_we", 64'(nwe), 64'(0));
            chk("state_kept", 64'(state), 64'(m_st));
         end
      endcase
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      model_reset();
   endtask

   initial begin
      model_reset();
      g_shown = 0;
      repeat (2) @(negedge clock);
      chk("rst_status", 64'(status), 64'(2'b10));
      chk("rst_data", 64'(data), 64'(0));
      chk("rst_pos", 64'(pos), 64'(0));
      chk("rst_we", 64'(disp_we), 64'(0));
      chk("rst_state", 64'(state), 64'(0));
      reset = 1'b0;

      run_cmd(4'd14, 0);
      run_cmd(4'd1, 0); run_cmd(4'd2, 0); run_cmd(4'd3, 0);
      run_cmd(4'd10, 0);
      run_cmd(4'd4, 0); run_cmd(4'd5, 0);
      run_cmd(4'd14, 0);
      chk("sum_168", 64'(g_shown), 64'(168));
      chk("sum_state_hold", 64'(state), 64'(5));

      run_cmd(4'd1, 0); run_cmd(4'd2, 0);
      run_cmd(4'd15, 5);
      chk("backspace_1", 64'(g_shown), 64'(1));
      run_cmd(4'd4, 0);
      chk("after_glitch_14", 64'(g_shown), 64'(14));

      do_reset();
      for (int i = 0; i < DIGITS; i++) run_cmd(4'd9, 0);
      run_cmd(4'd9, 0);
      chk("reject_digit", 64'(g_shown), 64'(99999999));
      run_cmd(4'd12, 0); run_cmd(4'd2, 0); run_cmd(4'd14, 0);
      for (int i = 0; i < 100; i++) begin
         @(negedge clock);
         chk("err_hold", 64'({status, state, disp_we}),
             64'({2'b00, 3'd4, 1'b0}));
         cmd = 4'($urandom_range(0, 15));
         cmd_valid = 1'($urandom_range(0, 1));
      end
      cmd_valid = 1'b0;
      run_cmd(4'd3, 0);

      do_reset();
      run_cmd(4'd1, 0); run_cmd(4'd0, 0); run_cmd(4'd0, 0);
      run_cmd(4'd13, 0); run_cmd(4'd7, 0); run_cmd(4'd14, 0);
      chk("div_14", 64'(g_shown), 64'(14));
      do_reset();
      run_cmd(4'd5, 0); run_cmd(4'd13, 0); run_cmd(4'd0, 0);
      run_cmd(4'd14, 0);
      do_reset();
      run_cmd(4'd3, 0); run_cmd(4'd11, 0); run_cmd(4'd5, 0);
      run_cmd(4'd14, 0);
      do_reset();
      run_cmd(4'd3, 0); run_cmd(4'd10, 0); run_cmd(4'd11, 0);

      do_reset();
      run_cmd(4'd6, 0); run_cmd(4'd12, 0); run_cmd(4'd7, 0);
      run_cmd(4'd14, 0);
      chk("mul_42", 64'(g_shown), 64'(42));
      run_cmd(4'd10, 0); run_cmd(4'd8, 0); run_cmd(4'd14, 0);
      chk("chain_50", 64'(g_shown), 64'(50));
      run_cmd(4'd3, 0);
      chk("new_entry_3", 64'(g_shown), 64'(3));
      chk("new_entry_state", 64'(state), 64'(0));

      do_reset();
      run_cmd(4'd9, 0); run_cmd(4'd12, 0); run_cmd(4'd9, 0);
      @(negedge clock);
      cmd = 4'd14; cmd_valid = 1'b1;
      @(posedge clock);
      @(negedge clock);
      cmd_valid = 1'b0;
      repeat (9) @(negedge clock);
      chk("mid_exec_state", 64'(state), 64'(2));
      reset = 1'b1;
      #1;
      chk("async_rst_status", 64'(status), 64'(2'b10));
      chk("async_rst_we", 64'(disp_we), 64'(0));
      chk("async_rst_state", 64'(state), 64'(0));
      @(negedge clock);
      reset = 1'b0;
      model_reset();
      run_cmd(4'd2, 0); run_cmd(4'd10, 0); run_cmd(4'd2, 0);
      run_cmd(4'd14, 0);
      chk("fresh_4", 64'(g_shown), 64'(4));

      do_reset();
      for (int r = 0; r < 10; r++) begin
         for (int j = 0; j < int'($urandom_range(1, 4)); j++)
            run_cmd(4'($urandom_range(0, 9)), 0);
         if ($urandom_range(0, 3) == 0) run_cmd(4'd15, 0);
         run_cmd(4'(10 + $urandom_range(0, 3)), 0);
         for (int j = 0; j < int'($urandom_range(1, 3)); j++)
            run_cmd(4'($urandom_range(0, 9)), 0);
         run_cmd(4'd14, 0);
         if (m_st == ME) do_reset();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
